// File: rtl/mem_port_pkg.sv
// Shared widths, timeout limit and controller state encoding for the memory port.
package mem_port_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port.sv
// Memory port: MAR/MDR registers plus a three-state bus controller that runs
// single read/write handshakes against an external memory, with a timeout.
module mem_port
    import mem_port_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              lmar,
    input  logic              spmar,
    input  logic              pcmar,
    input  logic [ADDR_W-1:0] sp,
    input  logic [ADDR_W-1:0] pc,
    input  logic              lmdr,
    input  logic              mdrz,
    input  logic              mdrm,
    input  logic [DATA_W-1:0] zbus,
    input  logic              mrw,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack
);

    // Counter value seen on the last cycle before the timeout fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rd_cmd;
    logic             timeout;

    // A write request takes precedence over a read, and a Z-bus load
    // suppresses the memory read entirely.
    assign rd_cmd  = lmdr & mdrm & ~mdrz & ~mrw;
    assign timeout = (cnt == CNT_LAST) & ~mem_ack;

    // Controller state register; reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and bus handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mrw)         state_nxt = ST_WR;
                else if (rd_cmd) state_nxt = ST_RD;
            end
            ST_RD: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || timeout) state_nxt = ST_IDLE;
            end
            ST_WR: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack || timeout) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The memory always sees the current register contents.
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

    // MAR/MDR loads, timeout counting and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mar <= '0;
            mdr <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (lmar) begin
                        if (spmar)      mar <= sp;
                        else if (pcmar) mar <= pc;
                    end
                    if (lmdr && mdrz) mdr <= zbus;
                end
                ST_RD, ST_WR: begin
                    if (mem_ack) begin
                        if (state == ST_RD) mdr <= mem_rdata;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout) err <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: randomized register loads and memory
// transactions compared against a transaction-level model of MAR, MDR and err.
module tb_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        lmar, spmar, pcmar;
    logic [15:0] sp, pc;
    logic        lmdr, mdrz, mdrm;
    logic [15:0] zbus;
    logic        mrw;
    logic [15:0] mar, mdr;
    logic        busy, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_mar, m_mdr;
    logic        m_err;

    mem_port dut (
        .clk(clk), .reset(reset),
        .lmar(lmar), .spmar(spmar), .pcmar(pcmar), .sp(sp), .pc(pc),
        .lmdr(lmdr), .mdrz(mdrz), .mdrm(mdrm), .zbus(zbus), .mrw(mrw),
        .mar(mar), .mdr(mdr), .busy(busy), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic clear_ctl();
        lmar = 0; spmar = 0; pcmar = 0; lmdr = 0; mdrz = 0; mdrm = 0; mrw = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a read or write, ack it on wait cycle ack_at (0 = never), and
    // report how many busy cycles were seen plus bus/register deviations.
    task automatic do_txn(input bit wr, input int ack_at, input logic [15:0] data,
                          output int cyc, output int bad);
        if (wr) mrw = 1;
        else begin lmdr = 1; mdrm = 1; end
        step();
        clear_ctl();
        cyc = 0;
        bad = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (mem_req !== 1'b1 || mem_we !== wr || mem_addr !== m_mar ||
                mar !== m_mar || mdr !== m_mdr) bad++;
            if (wr && mem_wdata !== m_mdr) bad++;
            if (cyc == ack_at) begin mem_ack = 1; mem_rdata = data; end
            step();
            mem_ack = 0;
        end
    endtask

    task automatic load_zbus(input logic [15:0] d);
        lmdr = 1; mdrz = 1; zbus = d;
        step();
        clear_ctl();
        m_mdr = d;
    endtask

    task automatic load_mar_sp(input logic [15:0] a);
        lmar = 1; spmar = 1; sp = a;
        step();
        clear_ctl();
        m_mar = a;
    endtask

    task automatic test_reset();
        reset = 1; clear_ctl();
        sp = 0; pc = 0; zbus = 0; mem_rdata = 0; mem_ack = 0;
        #3;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_checks++; if (mar !== 16'h0)    begin n_fail++; $display("FAIL reset_mar: got %h want 0000", mar); end
        n_checks++; if (mdr !== 16'h0)    begin n_fail++; $display("FAIL reset_mdr: got %h want 0000", mdr); end
        n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk);
        reset = 0;
        m_mar = 0; m_mdr = 0; m_err = 0;
    endtask

    task automatic test_mar_load();
        sp = 16'h1234; pc = 16'h00FF; lmar = 1; spmar = 1; pcmar = 1;
        step();
        clear_ctl();
        m_mar = 16'h1234;
        n_checks++; if (mar !== m_mar) begin n_fail++; $display("FAIL mar_priority: got %h want %h", mar, m_mar); end
        for (int i = 0; i < 10; i++) begin
            sp = 16'($urandom); pc = 16'($urandom);
            lmar = 1'($urandom); spmar = 1'($urandom); pcmar = 1'($urandom);
            if (lmar) begin
                if (spmar)      m_mar = sp;
                else if (pcmar) m_mar = pc;
            end
            step();
            clear_ctl();
            n_checks++; if (mar !== m_mar || busy !== 1'b0) begin n_fail++; $display("FAIL mar_rand%0d: got mar=%h busy=%b want mar=%h busy=0", i, mar, busy, m_mar); end
        end
    endtask

    task automatic test_zbus_load();
        lmdr = 1; mdrz = 1; mdrm = 1; zbus = 16'h7E01;
        step();
        clear_ctl();
        m_mdr = 16'h7E01;
        n_checks++; if (mdr !== m_mdr)      begin n_fail++; $display("FAIL zbus_mdr: got %h want %h", mdr, m_mdr); end
        n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zbus_noreq: got req=%b busy=%b want 0 0", mem_req, busy); end
        n_checks++; if (mem_wdata !== m_mdr) begin n_fail++; $display("FAIL zbus_wdata: got %h want %h", mem_wdata, m_mdr); end
    endtask

    task automatic test_read();
        int cyc, bad, lat;
        logic [15:0] d;
        load_mar_sp(16'h0040);
        do_txn(0, 3, 16'hBEEF, cyc, bad);
        m_mdr = 16'hBEEF;
        n_checks++; if (cyc !== 3)    begin n_fail++; $display("FAIL read_busy_cycles: got %0d want 3", cyc); end
        n_checks++; if (bad !== 0)    begin n_fail++; $display("FAIL read_bus: got %0d bad cycles want 0", bad); end
        n_checks++; if (mdr !== m_mdr) begin n_fail++; $display("FAIL read_mdr: got %h want %h", mdr, m_mdr); end
        for (int i = 0; i < 4; i++) begin
            load_mar_sp(16'($urandom));
            d = 16'($urandom);
            lat = $urandom_range(1, 6);
            do_txn(0, lat, d, cyc, bad);
            m_mdr = d;
            n_checks++; if (cyc !== lat || bad !== 0 || mdr !== m_mdr || busy !== 1'b0) begin n_fail++; $display("FAIL read_rand%0d: got cyc=%0d bad=%0d mdr=%h want cyc=%0d bad=0 mdr=%h", i, cyc, bad, mdr, lat, m_mdr); end
        end
    endtask

    task automatic test_write();
        int cyc, bad, lat;
        load_zbus(16'hA5A5);
        lmdr = 1; mdrm = 1;
        mem_rdata = 16'h0BAD;
        do_txn(1, 2, 16'h0BAD, cyc, bad);
        n_checks++; if (cyc !== 2 || bad !== 0) begin n_fail++; $display("FAIL write_over_read: got cyc=%0d bad=%0d want 2 0", cyc, bad); end
        n_checks++; if (mdr !== 16'hA5A5)       begin n_fail++; $display("FAIL write_mdr_kept: got %h want a5a5", mdr); end
        for (int i = 0; i < 3; i++) begin
            load_zbus(16'($urandom));
            pc = 16'($urandom);
            lmar = 1; pcmar = 1;
            m_mar = pc;
            lat = $urandom_range(1, 5);
            do_txn(1, lat, 16'($urandom), cyc, bad);
            n_checks++; if (cyc !== lat || bad !== 0 || mar !== m_mar || mdr !== m_mdr) begin n_fail++; $display("FAIL write_rand%0d: got cyc=%0d bad=%0d mar=%h want cyc=%0d bad=0 mar=%h", i, cyc, bad, mar, lat, m_mar); end
        end
    endtask

    task automatic test_ignore_busy();
        logic [15:0] d;
        load_zbus(16'h1111);
        lmdr = 1; mdrm = 1;
        step();
        clear_ctl();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start: got %b want 1", busy); end
        lmar = 1; spmar = 1; sp = ~m_mar; lmdr = 1; mdrz = 1; zbus = 16'h7E01; mrw = 1;
        step();
        clear_ctl();
        n_checks++; if (mar !== m_mar || mdr !== m_mdr) begin n_fail++; $display("FAIL busy_ignore: got mar=%h mdr=%h want %h %h", mar, mdr, m_mar, m_mdr); end
        n_checks++; if (busy !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL busy_still_read: got busy=%b we=%b want 1 0", busy, mem_we); end
        d = 16'($urandom);
        mem_ack = 1; mem_rdata = d;
        step();
        mem_ack = 0;
        m_mdr = d;
        n_checks++; if (mdr !== m_mdr || busy !== 1'b0) begin n_fail++; $display("FAIL busy_finish: got mdr=%h busy=%b want %h 0", mdr, busy, m_mdr); end
    endtask

    task automatic test_idle_ack();
        mem_ack = 1; mem_rdata = ~m_mdr;
        step();
        step();
        mem_ack = 0;
        n_checks++; if (mdr !== m_mdr || busy !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got mdr=%h busy=%b req=%b want %h 0 0", mdr, busy, mem_req, m_mdr); end
    endtask

    task automatic test_timeout();
        int cyc, bad;
        logic [15:0] d;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", err); end
        mem_rdata = ~m_mdr;
        do_txn(0, 0, ~m_mdr, cyc, bad);
        m_err = 1;
        n_checks++; if (cyc !== 15 || bad !== 0) begin n_fail++; $display("FAIL timeout_cycles: got cyc=%0d bad=%0d want 15 0", cyc, bad); end
        n_checks++; if (err !== m_err || mdr !== m_mdr || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_state: got err=%b mdr=%h busy=%b want 1 %h 0", err, mdr, busy, m_mdr); end
        d = 16'($urandom);
        do_txn(0, 2, d, cyc, bad);
        m_mdr = d;
        n_checks++; if (cyc !== 2 || mdr !== m_mdr || err !== m_err) begin n_fail++; $display("FAIL after_timeout: got cyc=%0d mdr=%h err=%b want 2 %h 1", cyc, mdr, err, m_mdr); end
        mem_rdata = 16'h5555;
        do_txn(1, 0, 16'h5555, cyc, bad);
        n_checks++; if (cyc !== 15 || err !== 1'b1 || mdr !== m_mdr) begin n_fail++; $display("FAIL wr_timeout: got cyc=%0d err=%b mdr=%h want 15 1 %h", cyc, err, mdr, m_mdr); end
    endtask

    task automatic test_reset_mid_write();
        int cyc, bad;
        load_mar_sp(16'hC0DE);
        load_zbus(16'hFACE);
        mrw = 1;
        step();
        clear_ctl();
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_active: got req=%b we=%b want 1 1", mem_req, mem_we); end
        #2 reset = 1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got req=%b busy=%b want 0 0", mem_req, busy); end
        n_checks++; if (mar !== 16'h0 || mdr !== 16'h0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regs: got mar=%h mdr=%h err=%b want 0 0 0", mar, mdr, err); end
        @(negedge clk);
        reset = 0;
        m_mar = 0; m_mdr = 0; m_err = 0;
        do_txn(0, 1, 16'h3C3C, cyc, bad);
        m_mdr = 16'h3C3C;
        n_checks++; if (cyc !== 1 || bad !== 0 || mdr !== m_mdr) begin n_fail++; $display("FAIL post_reset_read: got cyc=%0d bad=%0d mdr=%h want 1 0 %h", cyc, bad, mdr, m_mdr); end
    endtask

    task automatic test_back_to_back();
        int cyc, bad, lat, op;
        logic [15:0] d;
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 3);
            cyc = 0; bad = 0; lat = 0;
            case (op)
                0: begin
                    sp = 16'($urandom); pc = 16'($urandom);
                    lmar = 1; spmar = 1'($urandom); pcmar = 1'($urandom);
                    if (spmar)      m_mar = sp;
                    else if (pcmar) m_mar = pc;
                    step();
                    clear_ctl();
                end
                1: load_zbus(16'($urandom));
                2: begin
                    d = 16'($urandom);
                    lat = $urandom_range(1, 4);
                    do_txn(0, lat, d, cyc, bad);
                    m_mdr = d;
                end
                default: begin
                    lat = $urandom_range(1, 4);
                    do_txn(1, lat, 16'($urandom), cyc, bad);
                end
            endcase
            n_checks++; if (cyc !== lat || bad !== 0 || mar !== m_mar || mdr !== m_mdr || err !== m_err) begin n_fail++; $display("FAIL b2b_%0d op%0d: got cyc=%0d bad=%0d mar=%h mdr=%h err=%b want cyc=%0d mar=%h mdr=%h err=%b", i, op, cyc, bad, mar, mdr, err, lat, m_mar, m_mdr, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_mar_load();
        test_zbus_load();
        test_read();
        test_write();
        test_ignore_busy();
        test_idle_ack();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 clk  in  1  single clock; all registers update on rising edge (controller drives control word on falling edge).
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 lmar, spmar, pcmar  in  1 each  load MAR; source select SP / PC.
REQ-004 sp, pc  in  16 each  address sources for MAR.
REQ-005 lmdr, mdrz, mdrm  in  1 each  load MDR; source select Z bus / memory read.
REQ-006 zbus  in  16  ALU result bus.
REQ-007 mrw  in  1  write MDR to memory at MAR.
REQ-008 mar, mdr  out  16 each  register contents.
REQ-009 busy  out  1  memory transaction in progress; controller stalls.
REQ-010 err  out  1  sticky timeout flag.
REQ-011 mem_addr, mem_wdata  out  16 each; mem_rdata  in  16.
REQ-012 mem_req, mem_we  out  1 each; mem_ack  in  1.

Function
REQ-013 States: IDLE, RD, WR; busy SHALL equal (state != IDLE), combinationally.
REQ-014 IDLE, lmar=1: mar <= sp if spmar, else pc if pcmar, else unchanged; spmar wins when both set.
REQ-015 IDLE, lmdr=1 & mdrz=1: mdr <= zbus in one cycle, no memory access; mdrz wins over mdrm.
REQ-016 IDLE, lmdr=1 & mdrm=1 & mdrz=0: next state RD; timeout counter cleared.
REQ-017 IDLE, mrw=1: next state WR; mrw wins over a simultaneous read request; simultaneous lmar applies, and the write uses the new MAR value.
REQ-018 RD: mem_req=1, mem_we=0, mem_addr=mar; edge with mem_ack=1: mdr <= mem_rdata, state IDLE.
REQ-019 WR: mem_req=1, mem_we=1, mem_addr=mar, mem_wdata=mdr; edge with mem_ack=1: state IDLE.
REQ-020 Minimum latency: command at edge N, ack sampled at edge N+1, busy low after edge N+1.
REQ-021 IDLE: mem_req=0, mem_we=0; mem_addr=mar, mem_wdata=mdr.
REQ-022 lmar, lmdr, mrw SHALL be ignored while busy; mar/mdr SHALL stay stable during RD/WR except the REQ-018 load.
REQ-023 Timeout: 4-bit counter increments each RD/WR cycle without ack; on reaching 15 -> state IDLE, err <= 1, mdr unchanged.
REQ-024 err SHALL stay 1 until reset; it SHALL NOT block further transactions.
REQ-025 mem_ack in IDLE SHALL be ignored.

Reset
REQ-026 reset=1: state IDLE, mar=0, mdr=0, counter=0, err=0, mem_req=0, mem_we=0, busy=0, asynchronously.
REQ-027 reset mid-RD/WR: transaction aborted, mem_req deasserts without waiting for clk; no MDR update.

Structure
REQ-028 Package mem_port_pkg: state encoding, DATA_W=16, ADDR_W=16, TIMEOUT=15.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 sp=0x1234, pc=0x00FF, lmar=spmar=pcmar=1 -> mar=0x1234 after one edge.
REQ-031 mar=0x0040, lmdr=mdrm=1, ack after 3 cycles with mem_rdata=0xBEEF -> busy high 3 cycles, mdr=0xBEEF, mem_we=0 throughout.
REQ-032 mdr=0xA5A5, mrw=1 with lmdr=mdrm=1 -> WR taken, mem_we=1, mem_wdata=0xA5A5; no read, mdr stays 0xA5A5.
REQ-033 Read with mem_ack held 0 -> after 15 RD cycles state IDLE, err=1, mdr unchanged; next read with ack completes normally, err stays 1.
REQ-034 reset asserted during WR mid-cycle -> mem_req=0 immediately, mar=mdr=0, busy=0.
REQ-035 lmdr=mdrz=1, zbus=0x7E01, while busy -> ignored; same in IDLE -> mdr=0x7E01 next edge, mem_req stays 0.
